fetch_pc_unit: RTL and testbench

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/fetch_buffer.sv | 68 ++++++
 rtl/full_adder_32bit.sv | 25 ++
 rtl/fetch_pc_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_pc_unit.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage.
//   XLEN          : architectural register / address width
//   PC_INCR       : sequential PC step
//   fetch_state_t : fetch FSM states (RUN, HALT)
//   fetch_entry_t : one fetch buffer entry {pc, instr}
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INCR = 32'd4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous show-ahead FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   flush      : empties the FIFO; dominates push and pop
//   push       : write push_data (accepted when not full, or full with pop)
//   push_data  : entry to write
//   pop        : remove the head entry (ignored when empty)
//   head_data  : current head entry
//   empty      : no entries stored
//   count      : number of entries stored, 0..DEPTH
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2 * XLEN,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             full, do_push, do_pop;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == FULL_COUNT);
  assign count     = count_reg;
  assign head_data = mem[rd_ptr_reg];

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/full_adder_32bit.sv
// 32-bit ripple-carry adder built from a chain of full-adder bit cells.
// Ports:
//   a, b : addends
//   cin  : carry into bit 0
//   sum  : a + b + cin, modulo 2^32
module full_adder_32bit
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cin,
  output logic [XLEN-1:0] sum
);

  always_comb begin : ripple
    logic carry;
    carry = cin;
    sum   = '0;
    for (int i = 0; i < XLEN; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction fetch PC unit: issues in-order requests to instruction
// memory under a credit limit, buffers responses for decode, and handles
// branch/jump redirects (aligned -> restart, misaligned -> HALT).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   redirect_valid      : taken branch/jump pulse from execute
//   redirect_target     : new PC for the redirect
//   imem_req/imem_addr  : memory request and its address (current PC)
//   imem_gnt            : request accepted this cycle
//   imem_rvalid/rdata   : in-order read response
//   if_valid/if_ready   : decode handshake
//   if_instr/if_pc      : head instruction and its PC
//   misaligned_err      : pulse on a redirect with target[1:0] != 0
module fetch_pc_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            misaligned_err
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW:0]   CREDIT_LIMIT = (CW + 1)'(BUF_DEPTH);

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next, resp_pc_reg, resp_pc_next;
  logic [XLEN-1:0] pc_plus4, resp_pc_plus4;
  logic [CW-1:0]   outstanding_reg, outstanding_next, drop_reg, drop_next;
  logic            init_done_reg;
  logic [CW-1:0]   buf_count;
  logic            buf_empty;
  fetch_entry_t    buf_head, buf_in;
  logic            redirect_take, redirect_bad, credit_ok;
  logic            accept, resp_ok, resp_drop, enqueue, dequeue;

  // resp_pc_reg tracks the PC of the oldest outstanding request, so the
  // response can be tagged without storing addresses per request.
  full_adder_32bit u_pc_inc (
    .a   (pc_reg),
    .b   (PC_INCR),
    .cin (1'b0),
    .sum (pc_plus4)
  );

  full_adder_32bit u_resp_pc_inc (
    .a   (resp_pc_reg),
    .b   (PC_INCR),
    .cin (1'b0),
    .sum (resp_pc_plus4)
  );

  assign redirect_take = (state_reg == RUN) && redirect_valid;
  assign redirect_bad  = redirect_take && (redirect_target[1:0] != 2'b00);
  // Requests in flight plus buffered entries never exceed the buffer size,
  // so every response always has a slot.
  assign credit_ok = ({1'b0, outstanding_reg} + {1'b0, buf_count}) < CREDIT_LIMIT;
  assign accept    = imem_req && imem_gnt;
  assign resp_ok   = imem_rvalid && (outstanding_reg != '0);
  assign resp_drop = resp_ok && (drop_reg != '0);
  assign enqueue   = resp_ok && !resp_drop && (state_reg == RUN) && !redirect_valid;
  assign dequeue   = if_valid && if_ready;
  assign buf_in    = {resp_pc_reg, imem_rdata};

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (2 * XLEN),
    .CW    (CW)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_take),
    .push      (enqueue),
    .push_data (buf_in),
    .pop       (dequeue),
    .head_data (buf_head),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= RUN;
    else       state_reg <= state_next;
  end

  // FSM: next state; HALT is left only through reset
  always_comb begin
    state_next = state_reg;
    if (redirect_bad) state_next = HALT;
  end

  // FSM: outputs. init_done_reg holds off the first request for one cycle
  // after reset is released.
  always_comb begin
    imem_req       = !reset && init_done_reg && (state_reg == RUN) &&
                     credit_ok && !redirect_valid;
    imem_addr      = reset ? RESET_PC : pc_reg;
    if_valid       = !reset && (state_reg == RUN) && !buf_empty && !redirect_valid;
    if_instr       = if_valid ? buf_head.instr : '0;
    if_pc          = if_valid ? buf_head.pc : '0;
    misaligned_err = !reset && redirect_bad;
  end

  // Datapath next-state. An aligned redirect marks every request still in
  // flight (after this cycle's response, which is itself discarded) for drop.
  always_comb begin
    pc_next          = pc_reg;
    resp_pc_next     = resp_pc_reg;
    outstanding_next = outstanding_reg;
    drop_next        = drop_reg;
    if (resp_ok)   outstanding_next = outstanding_reg - CNT_ONE;
    if (accept)    outstanding_next = outstanding_next + CNT_ONE;
    if (resp_drop) drop_next = drop_reg - CNT_ONE;
    if (accept)    pc_next = pc_plus4;
    if (enqueue)   resp_pc_next = resp_pc_plus4;
    if (redirect_take && !redirect_bad) begin
      pc_next      = redirect_target;
      resp_pc_next = redirect_target;
      drop_next    = outstanding_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg          <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      drop_reg        <= '0;
      init_done_reg   <= 1'b0;
    end else begin
      pc_reg          <= pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      init_done_reg   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: stimulus pushes expected request
// addresses and decode transfers into queues; a negedge monitor pops and
// compares whenever the DUT grants a request or hands over an instruction.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, redirect_valid, imem_req, imem_gnt, imem_rvalid;
  logic        if_valid, if_ready, misaligned_err;
  logic [31:0] redirect_target, imem_addr, imem_rdata, if_instr, if_pc;

  // second instance with a reset PC near the top of the address space
  logic        req2, rvalid2, ifv2, mis2;
  logic        gnt2 = 1'b1, ready2 = 1'b1, redir2 = 1'b0;
  logic [31:0] target2 = 32'h0, addr2, rdata2, instr2, pc2;

  fetch_pc_unit u_dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .misaligned_err(misaligned_err)
  );

  fetch_pc_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (
    .clk(clk), .reset(reset), .redirect_valid(redir2),
    .redirect_target(target2), .imem_req(req2), .imem_addr(addr2),
    .imem_gnt(gnt2), .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .if_valid(ifv2), .if_ready(ready2), .if_instr(instr2), .if_pc(pc2),
    .misaligned_err(mis2)
  );

  int total = 0, bad = 0;
  int grants = 0, delivers = 0;
  logic        resp_en;
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_out_q[$];
  logic [31:0] pend[$], pend2[$];
  logic [31:0] rec_a2[3], rec_p2[3];
  int          n_a2 = 0, n_p2 = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_stream(input logic [31:0] base);
    exp_addr_q.delete();
    exp_out_q.delete();
    for (int i = 0; i < 120; i++) begin
      exp_addr_q.push_back(base + 32'(i * 4));
      exp_out_q.push_back({base + 32'(i * 4), instr_of(base + 32'(i * 4))});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // memory model: response one cycle after grant, in order; resp_en holds them
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      if (imem_req && imem_gnt) pend.push_back(imem_addr);
      #2;
      if (resp_en && pend.size() > 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = instr_of(pend.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  initial begin
    rvalid2 = 1'b0;
    rdata2  = '0;
    forever begin
      @(posedge clk);
      if (req2 && gnt2) pend2.push_back(addr2);
      #2;
      if (pend2.size() > 0) begin
        rvalid2 = 1'b1;
        rdata2  = instr_of(pend2.pop_front());
      end else begin
        rvalid2 = 1'b0;
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (imem_req && imem_gnt) begin
      grants++;
      if (exp_addr_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_request: addr %h, no request required", imem_addr);
      end else begin
        check("imem_addr", imem_addr, exp_addr_q.pop_front());
      end
    end
    if (if_valid && if_ready) begin
      logic [63:0] e;
      delivers++;
      $display("xfer pc=%h instr=%h", if_pc, if_instr);
      if (exp_out_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_transfer: pc %h, no transfer required", if_pc);
      end else begin
        e = exp_out_q.pop_front();
        check("if_pc", if_pc, e[63:32]);
        check("if_instr", if_instr, e[31:0]);
      end
    end
    if (req2 && gnt2 && n_a2 < 3) begin rec_a2[n_a2] = addr2; n_a2++; end
    if (ifv2 && ready2 && n_p2 < 3) begin rec_p2[n_p2] = pc2; n_p2++; end
  end

  task automatic quiesce_and_check(input string name, input int min_items);
    imem_gnt = 1'b0;
    resp_en  = 1'b1;
    if_ready = 1'b1;
    repeat (6) tick();
    #2;
    check({name, "_no_loss"}, 32'(delivers), 32'(grants));
    check({name, "_progress"}, 32'(delivers >= min_items), 32'd1);
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
    imem_gnt = 1'b0; if_ready = 1'b1; resp_en = 1'b1;
    push_stream(32'h0);
    tick(); tick();
    @(negedge clk);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_mis_err", 32'(misaligned_err), 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_imem_addr2", addr2, 32'hFFFF_FFF8);

    // sequential fetch with gnt tied high
    tick();
    reset = 1'b0; imem_gnt = 1'b1; grants = 0; delivers = 0;
    @(negedge clk);
    check("post_rst_req", 32'(imem_req), 32'd0);
    check("post_rst_if_valid", 32'(if_valid), 32'd0);
    tick();
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);
    repeat (30) tick();

    // decode stall: credit caps work in flight at the buffer size
    if_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      #2;
      check("stall_inflight_le2", 32'((grants - delivers) <= 2), 32'd1);
    end
    check("stall_req_low", 32'(imem_req), 32'd0);
    if_ready = 1'b1;
    repeat (20) tick();
    quiesce_and_check("seq", 12);

    // redirect with two requests outstanding
    tick();
    resp_en = 1'b0; imem_gnt = 1'b1;
    repeat (4) tick();
    #2;
    check("two_outstanding", 32'(grants - delivers), 32'd2);
    check("credit_stall", 32'(imem_req), 32'd0);
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h0000_0100;
    push_stream(32'h0000_0100);
    grants = 0; delivers = 0;
    @(negedge clk);
    check("redir_mis_err", 32'(misaligned_err), 32'd0);
    tick();
    redirect_valid = 1'b0; resp_en = 1'b1;
    repeat (30) tick();
    quiesce_and_check("redir100", 8);

    // redirect, grant and response in the same cycle
    tick();
    imem_gnt = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h0000_0200;
    push_stream(32'h0000_0200);
    grants = 0; delivers = 0;
    @(negedge clk);
    check("req_in_redirect", 32'(imem_req), 32'd0);
    check("rvalid_in_redirect", 32'(imem_rvalid), 32'd1);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("dropped_no_entry", 32'(if_valid), 32'd0);
    check("req_after_redirect", 32'(imem_req), 32'd1);
    check("addr_after_redirect", imem_addr, 32'h0000_0200);
    repeat (20) tick();
    quiesce_and_check("redir200", 5);

    // misaligned redirect -> HALT until reset
    tick();
    imem_gnt = 1'b1;
    repeat (5) tick();
    redirect_valid = 1'b1; redirect_target = 32'h0000_0102;
    exp_addr_q.delete();
    exp_out_q.delete();
    @(negedge clk);
    check("mis_err_pulse", 32'(misaligned_err), 32'd1);
    for (int i = 0; i < 12; i++) begin
      tick();
      redirect_valid  = (i == 4) || (i == 8);
      redirect_target = (i == 4) ? 32'h0000_0300 : 32'h0000_0306;
      @(negedge clk);
      check("halt_req", 32'(imem_req), 32'd0);
      check("halt_if_valid", 32'(if_valid), 32'd0);
      check("halt_mis_err", 32'(misaligned_err), 32'd0);
    end
    tick();
    redirect_valid = 1'b0;

    // reset leaves HALT; then reset mid-transaction with late responses
    reset = 1'b1;
    push_stream(32'h0);
    tick(); tick();
    reset = 1'b0; grants = 0; delivers = 0;
    repeat (12) tick();
    resp_en = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    push_stream(32'h0);
    tick(); tick();
    reset = 1'b0; resp_en = 1'b1; grants = 0; delivers = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_resp_ignored", 32'(if_valid), 32'd0);
      tick();
    end
    repeat (20) tick();
    quiesce_and_check("post_reset", 8);

    // PC wrap on the second instance
    check("wrap_count", 32'(n_a2), 32'd3);
    check("wrap_addr0", rec_a2[0], 32'hFFFF_FFF8);
    check("wrap_addr1", rec_a2[1], 32'hFFFF_FFFC);
    check("wrap_addr2", rec_a2[2], 32'h0000_0000);
    check("wrap_pc_count", 32'(n_p2), 32'd3);
    check("wrap_pc0", rec_p2[0], 32'hFFFF_FFF8);
    check("wrap_pc1", rec_p2[1], 32'hFFFF_FFFC);
    check("wrap_pc2", rec_p2[2], 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
